// File: rtl/cla_pkg.sv
// Shared widths and payload types for the pipelined CLA adder.
// Types here match the default HALF_W; the top re-derives them from its own parameters.
package cla_pkg;
  localparam int CLA_HALF_W = 16;
  localparam int CLA_GRP_W  = 4;

  typedef logic [CLA_HALF_W-1:0] half_t;

  typedef struct packed {
    half_t a_hi;
    half_t b_hi;
    half_t sum_lo;
    logic  c16;
  } s1_pay_t;
endpackage

// File: rtl/cla16_core.sv
// Combinational HALF_W-bit carry-lookahead adder.
// Two lookahead levels: bit P/G -> group PG/GG -> group carries; no ripple between groups.
module cla16_core
  import cla_pkg::*;
#(
  parameter int HALF_W = CLA_HALF_W,
  parameter int GRP_W  = CLA_GRP_W
) (
  input  logic [HALF_W-1:0] a,
  input  logic [HALF_W-1:0] b,
  input  logic              cin,
  output logic [HALF_W-1:0] sum,
  output logic              cout,
  output logic              c_msb
);
  localparam int NGRP = HALF_W / GRP_W;

  logic [HALF_W-1:0] w_p, w_g, w_c;
  logic [NGRP-1:0]   w_gp, w_gg;
  logic [NGRP:0]     w_gc;

  assign w_p = a ^ b;
  assign w_g = a & b;

  // Every carry is built as an explicit sum of products over the level below.
  always_comb begin
    logic v_t;
    logic v_c;
    w_gp = '0;
    w_gg = '0;
    w_gc = '0;
    w_c  = '0;
    v_t  = 1'b0;
    v_c  = 1'b0;
    for (int gi = 0; gi < NGRP; gi++) begin
      w_gp[gi] = &w_p[gi*GRP_W +: GRP_W];
      for (int j = 0; j < GRP_W; j++) begin
        v_t = w_g[gi*GRP_W + j];
        for (int k = j + 1; k < GRP_W; k++) v_t = v_t & w_p[gi*GRP_W + k];
        w_gg[gi] = w_gg[gi] | v_t;
      end
    end
    w_gc[0] = cin;
    for (int gi = 1; gi <= NGRP; gi++) begin
      v_t = cin;
      for (int k = 0; k < gi; k++) v_t = v_t & w_gp[k];
      v_c = v_t;
      for (int j = 0; j < gi; j++) begin
        v_t = w_gg[j];
        for (int k = j + 1; k < gi; k++) v_t = v_t & w_gp[k];
        v_c = v_c | v_t;
      end
      w_gc[gi] = v_c;
    end
    for (int gi = 0; gi < NGRP; gi++) begin
      for (int bi = 0; bi < GRP_W; bi++) begin
        v_t = w_gc[gi];
        for (int k = 0; k < bi; k++) v_t = v_t & w_p[gi*GRP_W + k];
        v_c = v_t;
        for (int j = 0; j < bi; j++) begin
          v_t = w_g[gi*GRP_W + j];
          for (int k = j + 1; k < bi; k++) v_t = v_t & w_p[gi*GRP_W + k];
          v_c = v_c | v_t;
        end
        w_c[gi*GRP_W + bi] = v_c;
      end
    end
  end

  assign sum   = w_p ^ w_c;
  assign cout  = w_gc[NGRP];
  assign c_msb = w_c[HALF_W-1];
endmodule

// File: rtl/cla_pipe_add32.sv
// Two-stage valid/ready pipelined adder: low-half CLA in stage 1, high-half CLA in stage 2.
// The low-half carry-out is registered between stages.
module cla_pipe_add32
  import cla_pkg::*;
#(
  parameter int HALF_W = CLA_HALF_W,
  parameter int GRP_W  = CLA_GRP_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*HALF_W-1:0] in_a,
  input  logic [2*HALF_W-1:0] in_b,
  input  logic                in_cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*HALF_W-1:0] out_sum,
  output logic                out_cout,
  output logic                out_ovf
);
  localparam int W = 2 * HALF_W;

  typedef struct packed {
    logic [HALF_W-1:0] a_hi;
    logic [HALF_W-1:0] b_hi;
    logic [HALF_W-1:0] sum_lo;
    logic              c16;
  } s1_t;

  // [1] = stage-1 valid, [2] = output valid
  logic [2:1]        r_vld_pipe;
  s1_t               r_s1;
  logic [W-1:0]      r_sum;
  logic              r_cout, r_ovf;

  logic              w_s2_adv, w_s1_adv;
  logic [HALF_W-1:0] w_sum_lo, w_sum_hi;
  logic              w_c16, w_cout_hi, w_cmsb_hi, w_unused_cmsb_lo;

  assign w_s2_adv = !r_vld_pipe[2] | out_ready;
  assign w_s1_adv = !r_vld_pipe[1] | w_s2_adv;
  assign in_ready = w_s1_adv;

  cla16_core #(.HALF_W(HALF_W), .GRP_W(GRP_W)) u_lo (
    .a     (in_a[HALF_W-1:0]),
    .b     (in_b[HALF_W-1:0]),
    .cin   (in_cin),
    .sum   (w_sum_lo),
    .cout  (w_c16),
    .c_msb (w_unused_cmsb_lo)
  );

  cla16_core #(.HALF_W(HALF_W), .GRP_W(GRP_W)) u_hi (
    .a     (r_s1.a_hi),
    .b     (r_s1.b_hi),
    .cin   (r_s1.c16),
    .sum   (w_sum_hi),
    .cout  (w_cout_hi),
    .c_msb (w_cmsb_hi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
    end else begin
      if (w_s1_adv) r_vld_pipe[1] <= in_valid;
      if (w_s2_adv) r_vld_pipe[2] <= r_vld_pipe[1];
    end
  end

  // Data only loads when a real beat moves, so unaccepted inputs never enter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
    end else if (w_s1_adv && in_valid) begin
      r_s1.a_hi   <= in_a[W-1:HALF_W];
      r_s1.b_hi   <= in_b[W-1:HALF_W];
      r_s1.sum_lo <= w_sum_lo;
      r_s1.c16    <= w_c16;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_s2_adv && r_vld_pipe[1]) begin
      r_sum  <= {w_sum_hi, r_s1.sum_lo};
      r_cout <= w_cout_hi;
      r_ovf  <= w_cmsb_hi ^ w_cout_hi;
    end
  end

  assign out_valid = r_vld_pipe[2];
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;
  assign out_ovf   = r_ovf;
endmodule
